// File: rtl/fb_write_arbiter.sv
// ---------------------------------------------------------------------------
// fb_write_arbiter
//
// Shares the single 64-bit framebuffer write port (DDR) between two
// requesters: port 0 = renderer, port 1 = overlay/clear engine. The winning
// write is latched, its address offset by a per-port base, and the DDR
// request/ready handshake is sequenced IDLE -> ISSUE -> COMPLETE -> IDLE.
//
// Ports
//   clk_sys          in   system clock
//   reset_n          in   synchronous reset, active low
//   req0 / req1      in   write request, held until readyN seen low
//   addr0 / addr1    in   28-bit byte address, stable while reqN high
//   data0 / data1    in   64-bit write data, stable while reqN high
//   ready0 / ready1  out  1 = idle/not accepted, 0 = accepted and in flight
//   ddr_addr         out  latched addrN + BASEN (28-bit wrap)
//   ddr_data         out  latched dataN
//   ddr_req          out  DDR write request
//   ddr_ready        in   DDR: low = accepted, back high = complete
//   grant            out  one-hot owner of current transfer, 0 when idle
//   timeout          out  sticky flag, set when the transfer timer hits TIMEOUT
//
// Configuration
//   FB_ARB_ROUND_ROBIN_EN  defined: simultaneous requests alternate ports.
//                          undefined: fixed priority, port 0 wins.
// ---------------------------------------------------------------------------
module fb_write_arbiter #(
    parameter logic [27:0] BASE0   = 28'h0000000,
    parameter logic [27:0] BASE1   = 28'h0060000,
    parameter logic [9:0]  TIMEOUT = 10'd1023
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic        req0,
    input  logic [27:0] addr0,
    input  logic [63:0] data0,
    output logic        ready0,
    input  logic        req1,
    input  logic [27:0] addr1,
    input  logic [63:0] data1,
    output logic        ready1,
    output logic [27:0] ddr_addr,
    output logic [63:0] ddr_data,
    output logic        ddr_req,
    input  logic        ddr_ready,
    output logic [1:0]  grant,
    output logic        timeout
);

    // Bases are kept 8-byte aligned so a 64-bit beat never straddles a word.
    localparam logic [27:0] L_BASE0 = {BASE0[27:3], 3'b000};
    localparam logic [27:0] L_BASE1 = {BASE1[27:3], 3'b000};

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_ISSUE    = 2'd1,
        S_COMPLETE = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    logic        r_ready0,   w_ready0_nxt;
    logic        r_ready1,   w_ready1_nxt;
    logic        r_ddr_req,  w_ddr_req_nxt;
    logic [27:0] r_ddr_addr, w_ddr_addr_nxt;
    logic [63:0] r_ddr_data, w_ddr_data_nxt;
    logic [1:0]  r_grant,    w_grant_nxt;
    logic        r_timeout,  w_timeout_nxt;
    logic [9:0]  r_timer,    w_timer_nxt;

    logic        w_cand0;
    logic        w_cand1;
    logic        w_pick_vld;
    logic        w_pick1;

`ifdef FB_ARB_ROUND_ROBIN_EN
    logic        r_last, w_last_nxt;
`endif

    // A port is only a candidate while its ready is high; this is what keeps
    // a held request from being taken twice for the same write.
    assign w_cand0    = req0 & r_ready0;
    assign w_cand1    = req1 & r_ready1;
    assign w_pick_vld = w_cand0 | w_cand1;

`ifdef FB_ARB_ROUND_ROBIN_EN
    // On a tie, take the port that did not win last time.
    assign w_pick1 = w_cand1 & (~w_cand0 | ~r_last);
`else
    assign w_pick1 = w_cand1 & ~w_cand0;
`endif

    // ---------------- state register ----------------
    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:     if (w_pick_vld) w_state_nxt = S_ISSUE;
            S_ISSUE:    if (!ddr_ready) w_state_nxt = S_COMPLETE;
            S_COMPLETE: if (ddr_ready)  w_state_nxt = S_IDLE;
            default:    w_state_nxt = S_IDLE;
        endcase
    end

    // ---------------- output / datapath next values ----------------
    always_comb begin
        w_ready0_nxt   = r_ready0;
        w_ready1_nxt   = r_ready1;
        w_ddr_req_nxt  = r_ddr_req;
        w_ddr_addr_nxt = r_ddr_addr;
        w_ddr_data_nxt = r_ddr_data;
        w_grant_nxt    = r_grant;
        w_timeout_nxt  = r_timeout;
        w_timer_nxt    = r_timer;
`ifdef FB_ARB_ROUND_ROBIN_EN
        w_last_nxt     = r_last;
`endif
        case (r_state)
            S_IDLE: begin
                if (w_pick_vld) begin
                    w_ddr_req_nxt = 1'b1;
                    w_timer_nxt   = '0;
`ifdef FB_ARB_ROUND_ROBIN_EN
                    w_last_nxt    = w_pick1;
`endif
                    if (w_pick1) begin
                        w_ddr_addr_nxt = addr1 + L_BASE1;
                        w_ddr_data_nxt = data1;
                        w_grant_nxt    = 2'b10;
                        w_ready1_nxt   = 1'b0;
                    end else begin
                        w_ddr_addr_nxt = addr0 + L_BASE0;
                        w_ddr_data_nxt = data0;
                        w_grant_nxt    = 2'b01;
                        w_ready0_nxt   = 1'b0;
                    end
                end
            end
            S_ISSUE: begin
                if (!ddr_ready) w_ddr_req_nxt = 1'b0;
            end
            S_COMPLETE: begin
                // The non-granted ready is already high, so releasing both
                // only affects the owner.
                if (ddr_ready) begin
                    w_ready0_nxt = 1'b1;
                    w_ready1_nxt = 1'b1;
                    w_grant_nxt  = 2'b00;
                end
            end
            default: begin
                w_ddr_req_nxt = 1'b0;
            end
        endcase

        // Timer runs while a transfer is outstanding and saturates; the flag
        // only reports, the FSM keeps waiting on the DDR side.
        if (r_state == S_ISSUE || r_state == S_COMPLETE) begin
            if (r_timer != 10'h3FF) w_timer_nxt = r_timer + 10'd1;
            if (r_timer == TIMEOUT) w_timeout_nxt = 1'b1;
        end
    end

    // ---------------- output / datapath registers ----------------
    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            r_ready0   <= 1'b1;
            r_ready1   <= 1'b1;
            r_ddr_req  <= 1'b0;
            r_ddr_addr <= '0;
            r_ddr_data <= '0;
            r_grant    <= 2'b00;
            r_timeout  <= 1'b0;
            r_timer    <= '0;
`ifdef FB_ARB_ROUND_ROBIN_EN
            r_last     <= 1'b1;
`endif
        end else begin
            r_ready0   <= w_ready0_nxt;
            r_ready1   <= w_ready1_nxt;
            r_ddr_req  <= w_ddr_req_nxt;
            r_ddr_addr <= w_ddr_addr_nxt;
            r_ddr_data <= w_ddr_data_nxt;
            r_grant    <= w_grant_nxt;
            r_timeout  <= w_timeout_nxt;
            r_timer    <= w_timer_nxt;
`ifdef FB_ARB_ROUND_ROBIN_EN
            r_last     <= w_last_nxt;
`endif
        end
    end

    assign ready0   = r_ready0;
    assign ready1   = r_ready1;
    assign ddr_req  = r_ddr_req;
    assign ddr_addr = r_ddr_addr;
    assign ddr_data = r_ddr_data;
    assign grant    = r_grant;
    assign timeout  = r_timeout;

endmodule

// File: tb/tb_fb_write_arbiter.sv
// ---------------------------------------------------------------------------
// tb_fb_write_arbiter
//
// Directed checks of reset, single-port transfers, address wrap, timeout and
// mid-transfer reset, followed by randomized rounds in which both requesters
// hold their requests across several writes. Expected DDR transfers are
// derived at round start from the arbitration rule and queued; a monitor
// pops one entry each time ddr_req rises.
// ---------------------------------------------------------------------------
module tb_fb_write_arbiter;

    localparam logic [27:0] B0 = 28'h0000000;
    localparam logic [27:0] B1 = 28'h0060000;
    localparam logic [9:0]  TO = 10'd1023;
    localparam logic [27:0] MB0 = B0 & 28'hFFFFFF8;
    localparam logic [27:0] MB1 = B1 & 28'hFFFFFF8;

    logic        clk_sys = 1'b0;
    logic        reset_n;
    logic [1:0]  req;
    logic [27:0] addr [2];
    logic [63:0] data [2];
    logic [1:0]  rdy;
    logic [27:0] ddr_addr;
    logic [63:0] ddr_data;
    logic        ddr_req;
    logic        ddr_ready;
    logic [1:0]  grant;
    logic        timeout;

    fb_write_arbiter #(.BASE0(B0), .BASE1(B1), .TIMEOUT(TO)) dut (
        .clk_sys   (clk_sys),
        .reset_n   (reset_n),
        .req0      (req[0]),
        .addr0     (addr[0]),
        .data0     (data[0]),
        .ready0    (rdy[0]),
        .req1      (req[1]),
        .addr1     (addr[1]),
        .data1     (data[1]),
        .ready1    (rdy[1]),
        .ddr_addr  (ddr_addr),
        .ddr_data  (ddr_data),
        .ddr_req   (ddr_req),
        .ddr_ready (ddr_ready),
        .grant     (grant),
        .timeout   (timeout)
    );

    always #5 clk_sys = ~clk_sys;

    typedef struct {
        logic [1:0]  g;
        logic [27:0] a;
        logic [63:0] d;
    } exp_t;

    typedef struct {
        logic [27:0] a;
        logic [63:0] d;
    } item_t;

    exp_t  q_exp[$];
    item_t q0[$];
    item_t q1[$];

    int   errors = 0;
    int   checks = 0;
    bit   mon_en = 0;
    bit   done   = 0;
    logic m_last;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic bound_fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: wait bound expired", name);
    endtask

    function automatic bit pop_item(input int p, output item_t it);
        it.a = '0;
        it.d = '0;
        if (p == 0) begin
            if (q0.size() == 0) return 1'b0;
            it = q0.pop_front();
        end else begin
            if (q1.size() == 0) return 1'b0;
            it = q1.pop_front();
        end
        return 1'b1;
    endfunction

    // Monitor: one expected entry per rising edge of ddr_req.
    initial begin : monitor
        logic prev;
        exp_t e;
        prev = 1'b0;
        forever begin
            @(negedge clk_sys);
            if (mon_en && ddr_req === 1'b1 && prev !== 1'b1) begin
                if (q_exp.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_xfer: grant %0b addr %0h with nothing expected", grant, ddr_addr);
                end else begin
                    e = q_exp.pop_front();
                    chk("sb_grant", grant, e.g);
                    chk("sb_addr", ddr_addr, e.a);
                    chk("sb_data", ddr_data, e.d);
                    chk("sb_ready_owner", rdy[e.g == 2'b10 ? 1 : 0], 0);
                    chk("sb_ready_other", rdy[e.g == 2'b10 ? 0 : 1], 1);
                end
            end
            prev = ddr_req;
        end
    end

    // Requester: holds req and presents the next item as soon as the current
    // one is accepted, so back-to-back requests stay pending.
    task automatic run_port(input int p);
        item_t it;
        bit    have;
        int    n;
        have = pop_item(p, it);
        while (have) begin
            req[p]  = 1'b1;
            addr[p] = it.a;
            data[p] = it.d;
            n = 0;
            do begin @(negedge clk_sys); n++; end while (rdy[p] !== 1'b0 && n < 3000);
            if (rdy[p] !== 1'b0) begin
                bound_fail($sformatf("port%0d_accept", p));
                req[p] = 1'b0;
                return;
            end
            have = pop_item(p, it);
            if (have) begin
                addr[p] = it.a;
                data[p] = it.d;
            end else begin
                req[p] = 1'b0;
            end
            n = 0;
            do begin @(negedge clk_sys); n++; end while (rdy[p] !== 1'b1 && n < 200);
            if (rdy[p] !== 1'b1) begin
                bound_fail($sformatf("port%0d_done", p));
                req[p] = 1'b0;
                return;
            end
        end
    endtask

    // DDR responder with random accept/complete delays; sometimes lowers
    // ddr_ready before the next request to exercise first-cycle acceptance.
    task automatic run_ddr();
        bit pre;
        int n;
        pre = 1'b0;
        while (!done) begin
            while (ddr_req !== 1'b1 && !done) @(negedge clk_sys);
            if (done) break;
            if (!pre) begin
                repeat ($urandom_range(0, 3)) @(negedge clk_sys);
                ddr_ready = 1'b0;
            end
            n = 0;
            while (ddr_req === 1'b1 && n < 50) begin @(negedge clk_sys); n++; end
            if (n >= 50) bound_fail("ddr_req_drop");
            if (pre) chk("ddr_req_pulse", n, 1);
            repeat ($urandom_range(0, 3)) @(negedge clk_sys);
            ddr_ready = 1'b1;
            @(negedge clk_sys);
            pre = 1'($urandom_range(0, 1));
            if (pre) ddr_ready = 1'b0;
        end
        ddr_ready = 1'b1;
    endtask

    // Directed single-port transfer with explicit expected address.
    task automatic do_xfer(input int p, input logic [27:0] a, input logic [63:0] d,
                           input logic [27:0] exp_a, input int hold, input int lowc,
                           input string tag);
        req[p]  = 1'b1;
        addr[p] = a;
        data[p] = d;
        @(negedge clk_sys);
        chk({tag, "_ddr_req"}, ddr_req, 1);
        chk({tag, "_ddr_addr"}, ddr_addr, exp_a);
        chk({tag, "_ddr_data"}, ddr_data, d);
        chk({tag, "_grant"}, grant, (p == 1) ? 2'b10 : 2'b01);
        chk({tag, "_ready_owner"}, rdy[p], 0);
        chk({tag, "_ready_other"}, rdy[1-p], 1);
        req[p] = 1'b0;
        if (hold > 0) begin
            repeat (hold) @(negedge clk_sys);
            chk({tag, "_issue_hold"}, ddr_req, 1);
        end
        ddr_ready = 1'b0;
        repeat (lowc) @(negedge clk_sys);
        chk({tag, "_req_dropped"}, ddr_req, 0);
        chk({tag, "_still_busy"}, rdy[p], 0);
        ddr_ready = 1'b1;
        @(negedge clk_sys);
        chk({tag, "_ready_back"}, rdy[p], 1);
        chk({tag, "_grant_clear"}, grant, 0);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin : stim
        int n;
        reset_n   = 1'b0;
        req       = 2'b00;
        addr[0]   = '0;
        addr[1]   = '0;
        data[0]   = '0;
        data[1]   = '0;
        ddr_ready = 1'b1;
        repeat (2) @(negedge clk_sys);
        chk("rst_ddr_req", ddr_req, 0);
        chk("rst_ready", rdy, 2'b11);
        chk("rst_grant", grant, 0);
        chk("rst_timeout", timeout, 0);
        chk("rst_ddr_addr", ddr_addr, 0);
        chk("rst_ddr_data", ddr_data, 0);
        reset_n = 1'b1;
        @(negedge clk_sys);

        do_xfer(0, 28'h10, 64'hA5, 28'h10, 2, 3, "p0_basic");
        do_xfer(1, 28'h8, 64'h1122334455667788, 28'h0060008, 0, 3, "p1_base");
        do_xfer(1, 28'hFFA0008, 64'hDEADBEEF, 28'h0000008, 0, 1, "p1_wrap");
        do_xfer(0, 28'hFFFFFF8, 64'h5A5A, 28'hFFFFFF8, 0, 2, "p0_top");

        // Timeout: DDR never accepts for well over TIMEOUT cycles.
        req[0]  = 1'b1;
        addr[0] = 28'h100;
        data[0] = 64'h77;
        @(negedge clk_sys);
        req[0] = 1'b0;
        chk("to_ddr_req", ddr_req, 1);
        repeat (1000) @(negedge clk_sys);
        chk("to_not_yet", timeout, 0);
        chk("to_still_waiting", ddr_req, 1);
        n = 0;
        while (timeout !== 1'b1 && n < 60) begin @(negedge clk_sys); n++; end
        chk("to_set", timeout, 1);
        ddr_ready = 1'b0;
        @(negedge clk_sys);
        ddr_ready = 1'b1;
        @(negedge clk_sys);
        chk("to_done_ready", rdy[0], 1);
        chk("to_sticky", timeout, 1);
        reset_n = 1'b0;
        @(negedge clk_sys);
        chk("to_cleared", timeout, 0);
        reset_n = 1'b1;
        @(negedge clk_sys);

        // Reset while in COMPLETE.
        req[0]  = 1'b1;
        addr[0] = 28'h200;
        data[0] = 64'h99;
        @(negedge clk_sys);
        req[0]    = 1'b0;
        ddr_ready = 1'b0;
        @(negedge clk_sys);
        chk("mid_in_complete", ddr_req, 0);
        reset_n = 1'b0;
        @(negedge clk_sys);
        reset_n = 1'b1;
        chk("mid_ddr_req", ddr_req, 0);
        chk("mid_ready", rdy, 2'b11);
        chk("mid_grant", grant, 0);
        ddr_ready = 1'b1;
        do_xfer(0, 28'h40, 64'hCAFE, 28'h40, 0, 2, "after_rst");

        // Randomized rounds, starting from a fresh reset.
        reset_n = 1'b0;
        @(negedge clk_sys);
        reset_n = 1'b1;
        m_last  = 1'b1;
        mon_en  = 1'b1;
        @(negedge clk_sys);
        for (int r = 0; r < 30; r++) begin
            int    n0, n1, i0, i1, p;
            item_t it;
            exp_t  e;
            n0 = (r == 0) ? 2 : $urandom_range(0, 4);
            n1 = (r == 0) ? 2 : $urandom_range(0, 4);
            if (n0 + n1 == 0) n0 = 1;
            q0.delete();
            q1.delete();
            for (int k = 0; k < n0 + n1; k++) begin
                if ($urandom_range(0, 3) == 0)
                    it.a = 28'hFFC0000 | 28'($urandom_range(0, 32'h3FFFF));
                else
                    it.a = 28'($urandom());
                it.d = {$urandom(), $urandom()};
                if (k < n0) q0.push_back(it);
                else        q1.push_back(it);
            end
            // Service order: while both have work, the arbitration rule
            // decides; otherwise the remaining port drains.
            i0 = 0;
            i1 = 0;
            while (i0 < n0 || i1 < n1) begin
                if (i0 < n0 && i1 < n1) begin
`ifdef FB_ARB_ROUND_ROBIN_EN
                    p = (m_last == 1'b0) ? 1 : 0;
`else
                    p = 0;
`endif
                end else begin
                    p = (i0 < n0) ? 0 : 1;
                end
                if (p == 0) begin
                    e.g = 2'b01; e.a = q0[i0].a + MB0; e.d = q0[i0].d; i0++;
                end else begin
                    e.g = 2'b10; e.a = q1[i1].a + MB1; e.d = q1[i1].d; i1++;
                end
                m_last = 1'(p);
                q_exp.push_back(e);
            end
            done = 1'b0;
            fork
                begin
                    fork
                        run_port(0);
                        run_port(1);
                    join
                    done = 1'b1;
                end
                run_ddr();
            join
            repeat (2) @(negedge clk_sys);
            chk("round_drained", q_exp.size(), 0);
            chk("round_idle_ready", rdy, 2'b11);
            q_exp.delete();
        end
        mon_en = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
